// File: rtl/rv32i_decode_stage.sv
// Registered RV32I instruction-decode stage.
// Takes an instruction word and its PC over a valid/ready handshake, decodes
// ALU control, operand selects, immediate, register indices and enables, and
// presents the bundle one cycle later to the execute stage.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid (and data) until it is taken. This stage holds
// every output stable while out_valid && !out_ready. in_ready is
// combinational: !out_valid || out_ready, so a drain and a new capture can
// happen in the same cycle without a bubble. flush wins over capture.
module rv32i_decode_stage #(
  parameter int PC_W          = 32,
  parameter int ILLEGAL_CHECK = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] pc_out,
  output logic [3:0]      alu_func,
  output logic            sub_sra,
  output logic [4:0]      shamt,
  output logic [31:0]     imm,
  output logic [1:0]      src_a_sel,
  output logic            src_b_sel,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            branch,
  output logic            jump,
  output logic [2:0]      funct3_out,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_XOR     = 4'b0001;
  localparam logic [3:0] ALU_OR      = 4'b0010;
  localparam logic [3:0] ALU_AND     = 4'b0011;
  localparam logic [3:0] ALU_SLL_IMM = 4'b0100;
  localparam logic [3:0] ALU_SLL_REG = 4'b0101;
  localparam logic [3:0] ALU_SRX_REG = 4'b0110;
  localparam logic [3:0] ALU_SRX_IMM = 4'b0111;
  localparam logic [3:0] ALU_SLT     = 4'b1000;
  localparam logic [3:0] ALU_SLTU    = 4'b1001;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      alu_func;
    logic            sub_sra;
    logic [4:0]      shamt;
    logic [31:0]     imm;
    logic [1:0]      src_a_sel;
    logic            src_b_sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_we;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic            illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;
  logic        accept;
  bundle_t     bundle_d, bundle_q;
  logic        valid_q;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Combinational decode of the incoming word into the next bundle.
  always_comb begin
    bundle_d        = '0;
    bad             = 1'b0;
    bundle_d.pc     = pc_in;
    bundle_d.shamt  = instr[24:20];
    bundle_d.rs1    = instr[19:15];
    bundle_d.rs2    = instr[24:20];
    bundle_d.rd     = instr[11:7];
    bundle_d.funct3 = f3;
    case (opcode)
      OPC_OP: begin
        bundle_d.reg_we = 1'b1;
        case (f3)
          3'b000: begin
            bundle_d.alu_func = ALU_ADD;
            bundle_d.sub_sra  = (f7 == F7_ALT);
          end
          3'b001: bundle_d.alu_func = ALU_SLL_REG;
          3'b010: bundle_d.alu_func = ALU_SLT;
          3'b011: bundle_d.alu_func = ALU_SLTU;
          3'b100: bundle_d.alu_func = ALU_XOR;
          3'b101: begin
            bundle_d.alu_func = ALU_SRX_REG;
            bundle_d.sub_sra  = instr[30];
          end
          3'b110: bundle_d.alu_func = ALU_OR;
          default: bundle_d.alu_func = ALU_AND;
        endcase
        if (!((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
          bad = 1'b1;
      end
      OPC_OP_IMM: begin
        bundle_d.reg_we    = 1'b1;
        bundle_d.src_b_sel = 1'b1;
        bundle_d.imm       = imm_i;
        case (f3)
          3'b000: bundle_d.alu_func = ALU_ADD;
          3'b001: begin
            bundle_d.alu_func = ALU_SLL_IMM;
            if (f7 != F7_BASE) bad = 1'b1;
          end
          3'b010: bundle_d.alu_func = ALU_SLT;
          3'b011: bundle_d.alu_func = ALU_SLTU;
          3'b100: bundle_d.alu_func = ALU_XOR;
          3'b101: begin
            bundle_d.alu_func = ALU_SRX_IMM;
            bundle_d.sub_sra  = instr[30];
            if ((f7 != F7_BASE) && (f7 != F7_ALT)) bad = 1'b1;
          end
          3'b110: bundle_d.alu_func = ALU_OR;
          default: bundle_d.alu_func = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        bundle_d.src_a_sel = SRC_A_ZERO;
        bundle_d.src_b_sel = 1'b1;
        bundle_d.imm       = imm_u;
        bundle_d.reg_we    = 1'b1;
      end
      OPC_AUIPC: begin
        bundle_d.src_a_sel = SRC_A_PC;
        bundle_d.src_b_sel = 1'b1;
        bundle_d.imm       = imm_u;
        bundle_d.reg_we    = 1'b1;
      end
      OPC_LOAD: begin
        bundle_d.src_b_sel = 1'b1;
        bundle_d.imm       = imm_i;
        bundle_d.mem_rd    = 1'b1;
        bundle_d.reg_we    = 1'b1;
        if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) bad = 1'b1;
      end
      OPC_STORE: begin
        bundle_d.src_b_sel = 1'b1;
        bundle_d.imm       = imm_s;
        bundle_d.mem_wr    = 1'b1;
        if (f3[2] || (f3 == 3'b011)) bad = 1'b1;
      end
      OPC_BRANCH: begin
        bundle_d.imm    = imm_b;
        bundle_d.branch = 1'b1;
        case (f3)
          3'b000, 3'b001: bundle_d.sub_sra  = 1'b1;
          3'b100, 3'b101: bundle_d.alu_func = ALU_SLT;
          3'b110, 3'b111: bundle_d.alu_func = ALU_SLTU;
          default:        bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        bundle_d.src_a_sel = SRC_A_PC;
        bundle_d.src_b_sel = 1'b1;
        bundle_d.imm       = imm_j;
        bundle_d.jump      = 1'b1;
        bundle_d.reg_we    = 1'b1;
      end
      OPC_JALR: begin
        bundle_d.src_b_sel = 1'b1;
        bundle_d.imm       = imm_i;
        bundle_d.jump      = 1'b1;
        bundle_d.reg_we    = 1'b1;
        if (f3 != 3'b000) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // A bad encoding must never cause architectural side effects downstream.
    if (bad) begin
      bundle_d.reg_we = 1'b0;
      bundle_d.mem_rd = 1'b0;
      bundle_d.mem_wr = 1'b0;
      bundle_d.branch = 1'b0;
      bundle_d.jump   = 1'b0;
    end
    if (bundle_d.rd == 5'd0) bundle_d.reg_we = 1'b0;
    bundle_d.illegal = (ILLEGAL_CHECK != 0) && bad;
  end

  // Output register: flush kills, capture loads, drain clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (accept) bundle_q <= bundle_d;
    end
  end

  assign out_valid  = valid_q;
  assign pc_out     = bundle_q.pc;
  assign alu_func   = bundle_q.alu_func;
  assign sub_sra    = bundle_q.sub_sra;
  assign shamt      = bundle_q.shamt;
  assign imm        = bundle_q.imm;
  assign src_a_sel  = bundle_q.src_a_sel;
  assign src_b_sel  = bundle_q.src_b_sel;
  assign rs1        = bundle_q.rs1;
  assign rs2        = bundle_q.rs2;
  assign rd         = bundle_q.rd;
  assign reg_we     = bundle_q.reg_we;
  assign mem_rd     = bundle_q.mem_rd;
  assign mem_wr     = bundle_q.mem_wr;
  assign branch     = bundle_q.branch;
  assign jump       = bundle_q.jump;
  assign funct3_out = bundle_q.funct3;
  assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference decoder and an expected queue.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [3:0]  alu_func;
  logic        sub_sra;
  logic [4:0]  shamt;
  logic [31:0] imm;
  logic [1:0]  src_a_sel;
  logic        src_b_sel;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_we, mem_rd, mem_wr, branch, jump;
  logic [2:0]  funct3_out;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {pc, instr} of a bundle the DUT should be presenting/holding.
  logic [63:0] exp_q[$];

  rv32i_decode_stage #(.PC_W(32), .ILLEGAL_CHECK(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .alu_func(alu_func), .sub_sra(sub_sra), .shamt(shamt), .imm(imm),
    .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump),
    .funct3_out(funct3_out), .illegal(illegal)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder, instruction-class level.
  typedef struct packed {
    logic [3:0]  fn;
    logic        ss;
    logic [1:0]  a;
    logic        b;
    logic        we, rdm, wrm, br, jp, ill;
    logic [31:0] imm;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    int ii, si, bi, ji;
    logic [3:0] op_fn  [8];
    logic [3:0] opi_fn [8];
    op_fn  = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd1, 4'd6, 4'd2, 4'd3};
    opi_fn = '{4'd0, 4'd4, 4'd8, 4'd9, 4'd1, 4'd7, 4'd2, 4'd3};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ii = $signed(w[31:20]);
    si = $signed({w[31:25], w[11:7]});
    bi = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    ji = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
    r = '0;
    ok = 1'b1;
    case (op)
      7'h33: begin
        r.fn = op_fn[f3];
        if (f3 == 3'd0) r.ss = (f7 == 7'h20);
        if (f3 == 3'd5) r.ss = w[30];
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        r.we = 1'b1;
      end
      7'h13: begin
        r.fn = opi_fn[f3];
        if (f3 == 3'd5) r.ss = w[30];
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        r.b = 1'b1; r.imm = ii; r.we = 1'b1;
      end
      7'h37: begin r.a = 2'd2; r.b = 1'b1; r.imm = w & 32'hFFFFF000; r.we = 1'b1; end
      7'h17: begin r.a = 2'd1; r.b = 1'b1; r.imm = w & 32'hFFFFF000; r.we = 1'b1; end
      7'h03: begin
        r.b = 1'b1; r.imm = ii; r.rdm = 1'b1; r.we = 1'b1;
        ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      end
      7'h23: begin r.b = 1'b1; r.imm = si; r.wrm = 1'b1; ok = (f3 < 3'd3); end
      7'h63: begin
        r.br = 1'b1; r.imm = bi;
        if (f3 < 3'd2) r.ss = 1'b1;
        else if (f3 < 3'd4) ok = 1'b0;
        else if (f3 < 3'd6) r.fn = 4'd8;
        else r.fn = 4'd9;
      end
      7'h6F: begin r.a = 2'd1; r.b = 1'b1; r.imm = ji; r.jp = 1'b1; r.we = 1'b1; end
      7'h67: begin r.b = 1'b1; r.imm = ii; r.jp = 1'b1; r.we = 1'b1; ok = (f3 == 3'd0); end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r.we = 1'b0; r.rdm = 1'b0; r.wrm = 1'b0; r.br = 1'b0; r.jp = 1'b0; r.ill = 1'b1;
    end
    if (w[11:7] == 5'd0) r.we = 1'b0;
    return r;
  endfunction

  // Scoreboard: compare presented bundle against the queue head.
  task automatic compare_head();
    ref_t r;
    logic [31:0] w;
    w = exp_q[0][31:0];
    r = ref_decode(w);
    check_eq("ctl", {alu_func, sub_sra, src_a_sel, src_b_sel, reg_we, mem_rd, mem_wr, branch, jump, illegal},
             {r.fn, r.ss, r.a, r.b, r.we, r.rdm, r.wrm, r.br, r.jp, r.ill});
    check_eq("fields", {shamt, rs1, rs2, rd, funct3_out},
             {w[24:20], w[19:15], w[24:20], w[11:7], w[14:12]});
    check_eq("imm", imm, r.imm);
    check_eq("pc", pc_out, exp_q[0][63:32]);
  endtask

  // One clock cycle: inputs already driven; check ready, advance the model, check outputs.
  task automatic cycle();
    logic exp_ready, take;
    #1;
    exp_ready = (exp_q.size() == 0) || out_ready;
    check_eq("in_ready", in_ready, exp_ready);
    take = in_valid && exp_ready && !flush;
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (take) exp_q.push_back({pc_in, instr});
    end
    #1;
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) compare_head();
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic rdy);
    in_valid = v; instr = w; pc_in = pc; out_ready = rdy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [31:0] w;
    int sel;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    w = $urandom;
    sel = $urandom_range(0, 10);
    if (sel < 9) w[6:0] = ops[sel];
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  logic [63:0] snap;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // SUB x3,x1,x2
    drive(1, 32'h402081B3, 32'h100, 1);
    cycle();
    check_eq("sub_func", alu_func, 4'b0000);
    check_eq("sub_sra", sub_sra, 1);
    check_eq("sub_regs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd3});
    check_eq("sub_srcb_we", {src_b_sel, reg_we}, 2'b01);

    // SRAI x5,x6,7 then SW x2,-4(x1)
    drive(1, 32'h40735293, 32'h104, 1);
    cycle();
    check_eq("srai_func", alu_func, 4'b0111);
    check_eq("srai_misc", {sub_sra, shamt, src_b_sel, rd}, {1'b1, 5'd7, 1'b1, 5'd5});
    drive(1, 32'hFE20AE23, 32'h108, 1);
    cycle();
    check_eq("sw_func", alu_func, 4'b0000);
    check_eq("sw_imm", imm, 32'hFFFFFFFC);
    check_eq("sw_en", {mem_wr, reg_we, funct3_out}, {1'b1, 1'b0, 3'b010});

    // Illegal word and ADD x0
    drive(1, 32'hFFFFFFFF, 32'h10C, 1);
    cycle();
    check_eq("ill_flag", illegal, 1);
    check_eq("ill_en", {reg_we, mem_rd, mem_wr, branch, jump}, 5'b0);
    drive(1, 32'h00000033, 32'h110, 1);
    cycle();
    check_eq("add_x0", {illegal, reg_we}, 2'b00);
    drive(0, 32'h0, 32'h0, 1);
    cycle();

    // Backpressure: two back-to-back words, sink stalled
    drive(1, 32'h00A00093, 32'h200, 0);  // ADDI x1,x0,10
    cycle();
    snap = {pc_out, imm, alu_func, rd, reg_we, 11'b0};
    drive(1, 32'h002081B3, 32'h204, 0);  // ADD x3,x1,x2
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_hold", {pc_out, imm, alu_func, rd, reg_we, 11'b0}, snap);
    end
    out_ready = 1'b1;
    cycle();
    check_eq("bp_second", pc_out, 32'h204);
    drive(0, 32'h0, 32'h0, 1);
    cycle();
    check_eq("bp_drained", out_valid, 0);

    // Flush with held bundle and same-cycle input
    drive(1, 32'h00500113, 32'h300, 0);
    cycle();
    flush = 1'b1;
    drive(1, 32'h00100193, 32'h304, 0);
    cycle();
    flush = 1'b0;
    check_eq("flush_kill", out_valid, 0);
    drive(1, 32'h06300213, 32'h308, 1);
    cycle();
    check_eq("flush_next_pc", pc_out, 32'h308);

    // Reset mid-stall
    drive(1, 32'h402081B3, 32'h400, 0);
    cycle();
    drive(0, 32'h0, 32'h0, 0);
    cycle();
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_zero", {pc_out, imm, alu_func, sub_sra, shamt, src_a_sel, src_b_sel,
                              rs1, rs2, rd, reg_we, mem_rd, mem_wr, branch, jump, funct3_out, illegal}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_ready", in_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(0, 32'h0, 32'h0, 1);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Registered instruction-decode stage for the RV32I core: the producer of ALU control codes.
- Accepts a fetched instruction word and PC over a valid/ready handshake.
- Decodes into ALU control (func, sub_sra, shamt), operand selects, immediate, register indices and memory/branch/jump enables.
- Presents the result one cycle later to the execute stage over a second valid/ready handshake, with flush support.

Parameters:
- PC_W, 32, width of the PC passed through.
- ILLEGAL_CHECK, 1, when 1 unsupported encodings assert illegal; when 0 illegal is tied 0. Enables for bad encodings are zeroed either way.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  instruction word valid
- in_ready  output  1  stage can accept
- instr  input  32  instruction word
- pc_in  input  PC_W  PC of instr
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute stage accepts
- pc_out  output  PC_W  registered pc_in
- alu_func  output  4  ALU operation code (encoding below)
- sub_sra  output  1  subtract / arithmetic-shift select
- shamt  output  5  instr[24:20]
- imm  output  32  sign-extended immediate (I/S/B/U/J per opcode)
- src_a_sel  output  2  00 rs1, 01 pc, 10 zero
- src_b_sel  output  1  0 rs2, 1 imm
- rs1, rs2, rd  output  5 each  register indices
- reg_we, mem_rd, mem_wr, branch, jump  output  1 each  enables
- funct3_out  output  3  funct3 (load/store size, branch condition)
- illegal  output  1  unsupported encoding

Behaviour:
- Reset (async, rst=1): out_valid=0, every registered output=0. A held bundle is discarded. in_ready=1 after release.
- in_ready = !out_valid || out_ready (combinational).
- Capture on in_valid && in_ready: the bundle is registered and out_valid=1 next cycle. Latency is 1 cycle.
- Backpressure: with out_valid && !out_ready, all outputs hold stable.
- Same-cycle out_ready and new capture: the new bundle replaces the old with no bubble.
- flush=1: out_valid=0 next cycle and any same-cycle input is dropped. flush has priority over capture.
- alu_func encoding:
  - 0000 add/sub
  - 0001 xor
  - 0010 or
  - 0011 and
  - 0100 sll-imm
  - 0101 sll-reg
  - 0110 srl/sra-reg
  - 0111 srl/sra-imm
  - 1000 slt
  - 1001 sltu
- OP (0110011):
  - f3 000: 0000; sub_sra = f7==0100000.
  - f3 001: 0101. f3 010: 1000. f3 011: 1001. f3 100: 0001.
  - f3 101: 0110; sub_sra = instr[30].
  - f3 110: 0010. f3 111: 0011.
  - f7 must be 0000000, or 0100000 only for f3 000/101; otherwise illegal.
  - src_b=rs2, reg_we=1.
- OP-IMM (0010011):
  - ADDI 0000 (sub_sra 0), SLTI 1000, SLTIU 1001, XORI 0001, ORI 0010, ANDI 0011.
  - SLLI 0100 (f7 must be 0).
  - SRLI/SRAI 0111, sub_sra = instr[30]; f7 must be 0000000 or 0100000.
  - src_b=imm, reg_we=1.
- LUI: add, A=zero, B=U-imm. AUIPC: add, A=pc, B=U-imm. Both reg_we=1.
- LOAD: add, A=rs1, B=I-imm, mem_rd=1, reg_we=1. Legal f3: 000, 001, 010, 100, 101.
- STORE: add, B=S-imm, mem_wr=1, reg_we=0. Legal f3: 000–010.
- BRANCH: A=rs1, B=rs2, branch=1, imm=B-imm.
  - BEQ/BNE: 0000 with sub_sra=1.
  - BLT/BGE: 1000.
  - BLTU/BGEU: 1001.
  - f3 010/011 illegal.
- JAL: add, A=pc, B=J-imm, jump=1, reg_we=1.
- JALR: add, A=rs1, B=I-imm, jump=1, reg_we=1. f3 must be 000.
- Any other opcode is illegal.
- Illegal encoding: reg_we, mem_rd, mem_wr, branch, jump forced 0. The bundle is still emitted with out_valid=1.
- rd==0 forces reg_we=0.
- For S- and B-type instructions, rd carries instr[11:7] but reg_we=0.

Test Plan:
- Reset mid-stall: rst pulsed while out_valid=1, out_ready=0 -> out_valid=0 immediately; all outputs 0; in_ready=1 after release.
- instr=0x402081B3 (SUB x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu_func=0000, sub_sra=1, rs1=1, rs2=2, rd=3, src_b_sel=0, reg_we=1.
- instr=0x40735293 (SRAI x5,x6,7) -> alu_func=0111, sub_sra=1, shamt=7, src_b_sel=1, rd=5; then 0xFE20AE23 (SW x2,-4(x1)) -> alu_func=0000, imm=0xFFFFFFFC, mem_wr=1, reg_we=0, funct3_out=010.
- Backpressure: two back-to-back valid instructions with out_ready=0 -> in_ready=0 after the first; first bundle held stable ≥3 cycles; second accepted the cycle out_ready=1; no loss or duplication.
- flush=1 and in_valid=1 in the same cycle with a held bundle -> out_valid=0 next cycle; the input is not captured; the next accept decodes normally.
- instr=0xFFFFFFFF -> illegal=1, all enables 0; instr=0x00000033 (ADD x0,x0,x0) -> illegal=0, reg_we=0.
